// File: rtl/sprite_line_fetcher_if.sv
// Fetch request handshake plus sprite ROM bus shared by the line fetcher and its surroundings.
// The fetcher is the initiator (master); the scanline controller and ROM sit on the slave side.
interface sprite_line_fetcher_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned IDX_W  = 3
) ();
  logic              start;
  logic [9:0]        line_y;
  logic [9:0]        sprite_x;
  logic [9:0]        sprite_y;
  logic              flip_h;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;

  modport master (
    input  start, line_y, sprite_x, sprite_y, flip_h, rom_q,
    output busy, done, rom_address
  );

  modport slave (
    output start, line_y, sprite_x, sprite_y, flip_h, rom_q,
    input  busy, done, rom_address
  );
endinterface

// File: rtl/sprite_line_fetcher.sv
// Prefetches one sprite row from the pattern ROM into a back line buffer during hblank, swaps it
// to the front on completion, and serves registered palette index / opacity by draw_x.
module sprite_line_fetcher #(
  parameter int unsigned SPR_W      = 32,
  parameter int unsigned SPR_H      = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned TRANSP_IDX = 0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  sprite_line_fetcher_if.master fetch,
  input  logic [9:0]           draw_x,
  output logic [IDX_W-1:0]     pix_idx,
  output logic                 pix_valid
);

  localparam int unsigned ColW = $clog2(SPR_W);
  localparam int unsigned RowW = ADDR_W - ColW;
  localparam logic [ColW-1:0]  ColMax    = ColW'(SPR_W - 1);
  localparam logic [9:0]       SprW10    = 10'(SPR_W);
  localparam logic [9:0]       SprH10    = 10'(SPR_H);
  localparam logic [IDX_W-1:0] TranspIdx = IDX_W'(TRANSP_IDX);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [RowW-1:0]     row_q, row_d;
  logic                flip_q, flip_d;
  logic                sel_q, sel_d;
  logic [1:0]          hit_q, hit_d;
  logic [1:0][9:0]     x_q, x_d;
  logic [ADDR_W-1:0]   rom_address_q, rom_address_d;
  logic [IDX_W-1:0]    pix_idx_q, pix_idx_d;
  logic                pix_valid_q, pix_valid_d;

  logic [IDX_W-1:0]    buf_q [2][SPR_W];
  logic                wr_en;
  logic [ColW-1:0]     wr_col;
  logic                back;
  logic [9:0]          row_in;
  logic                row_hit;

  // SPR_W is a power of two, so the mirrored column is simply the bitwise complement.
  function automatic logic [ADDR_W-1:0] addr_of(logic [RowW-1:0] r, logic [ColW-1:0] c,
                                                logic f);
    return {r, f ? ~c : c};
  endfunction

  assign back    = ~sel_q;
  assign row_in  = fetch.line_y - fetch.sprite_y;
  assign row_hit = (fetch.line_y >= fetch.sprite_y) && (row_in < SprH10);

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    flip_d        = flip_q;
    sel_d         = sel_q;
    hit_d         = hit_q;
    x_d           = x_q;
    rom_address_d = rom_address_q;
    wr_en         = 1'b0;
    wr_col        = col_q - ColW'(1);
    unique case (state_q)
      StIdle: begin
        if (fetch.start) begin
          flip_d     = fetch.flip_h;
          x_d[back]  = fetch.sprite_x;
          if (row_hit) begin
            row_d         = row_in[RowW-1:0];
            col_d         = '0;
            rom_address_d = addr_of(row_in[RowW-1:0], '0, fetch.flip_h);
            state_d       = StFetch;
          end else begin
            hit_d[back] = 1'b0;
            state_d     = StDone;
          end
        end
      end
      StFetch: begin
        // ROM data lags the address by one cycle, so col_q-1 is being returned now.
        wr_en = (col_q != '0);
        if (col_q == ColMax) begin
          state_d = StDrain;
        end else begin
          col_d         = col_q + ColW'(1);
          rom_address_d = addr_of(row_q, col_q + ColW'(1), flip_q);
        end
      end
      StDrain: begin
        wr_en       = 1'b1;
        wr_col      = ColMax;
        hit_d[back] = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        sel_d   = ~sel_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic [9:0]       front_x;
  logic [9:0]       dx;
  logic             in_span;
  logic [IDX_W-1:0] front_pix;

  always_comb begin
    front_x     = x_q[sel_q];
    dx          = draw_x - front_x;
    in_span     = hit_q[sel_q] && (draw_x >= front_x) && (dx < SprW10);
    front_pix   = buf_q[sel_q][dx[ColW-1:0]];
    pix_idx_d   = in_span ? front_pix : '0;
    pix_valid_d = in_span && (front_pix != TranspIdx);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      col_q         <= '0;
      row_q         <= '0;
      flip_q        <= 1'b0;
      sel_q         <= 1'b0;
      hit_q         <= '0;
      x_q           <= '0;
      rom_address_q <= '0;
      pix_idx_q     <= '0;
      pix_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      flip_q        <= flip_d;
      sel_q         <= sel_d;
      hit_q         <= hit_d;
      x_q           <= x_d;
      rom_address_q <= rom_address_d;
      pix_idx_q     <= pix_idx_d;
      pix_valid_q   <= pix_valid_d;
    end
  end

  // Line buffer contents need no reset; the hit flags gate every read.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      buf_q[back][wr_col] <= fetch.rom_q;
    end
  end

  assign fetch.rom_address = rom_address_q;
  assign fetch.busy        = (state_q == StFetch) || (state_q == StDrain);
  assign fetch.done        = (state_q == StDone);
  assign pix_idx           = pix_idx_q;
  assign pix_valid         = pix_valid_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Self-checking bench for sprite_line_fetcher: directed fetch timing, table-driven display
// vectors, corner sequences (miss, re-start, mid-fetch reset) and randomized fetches vs a model.
module tb_sprite_line_fetcher;

  logic       clock;
  logic       reset_n;
  logic [9:0] draw_x;
  logic [2:0] pix_idx;
  logic       pix_valid;

  sprite_line_fetcher_if #(.ADDR_W(10), .IDX_W(3)) bus ();

  sprite_line_fetcher dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .fetch    (bus),
    .draw_x   (draw_x),
    .pix_idx  (pix_idx),
    .pix_valid(pix_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] mem [1024];
  always @(posedge clock) bus.rom_q <= mem[bus.rom_address];

  int tests  = 0;
  int failed = 0;

  // Reference front line: what the most recently completed fetch should be showing.
  logic [2:0] ref_line [32];
  bit         ref_hit;
  int         ref_x;

  typedef struct {
    logic       flip;
    logic [9:0] dx;
    logic [2:0] idx;
    logic       v;
  } vec_t;
  vec_t tab [15];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue a start and check address/busy/done cycle by cycle, then update the reference.
  task automatic fetch_check(input logic [9:0] ly, input logic [9:0] sx, input logic [9:0] sy,
                             input logic f, input bit repulse);
    int         row;
    bit         hit;
    int         last_c;
    int         col;
    logic [9:0] prev_addr;
    logic [9:0] exp_addr;
    row       = int'(ly) - int'(sy);
    hit       = (row >= 0) && (row < 32);
    last_c    = hit ? 34 : 1;
    prev_addr = bus.rom_address;
    bus.line_y   = ly;
    bus.sprite_x = sx;
    bus.sprite_y = sy;
    bus.flip_h   = f;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      if (hit) begin
        col      = (c <= 32) ? c - 1 : 31;
        exp_addr = 10'(row * 32 + (f ? 31 - col : col));
      end else begin
        exp_addr = prev_addr;
      end
      chk("rom_address", bus.rom_address, exp_addr);
      chk("busy", bus.busy, hit && (c <= 33));
      chk("done", bus.done, c == last_c);
      if (repulse && c == 10) begin
        bus.start    = 1'b1;
        bus.line_y   = ly + 10'd1;
        bus.sprite_x = sx + 10'd5;
        bus.flip_h   = ~f;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    chk("done_after", bus.done, 1'b0);
    ref_hit = hit;
    ref_x   = int'(sx);
    if (hit) begin
      for (int c = 0; c < 32; c++) ref_line[c] = mem[row * 32 + (f ? 31 - c : c)];
    end
  endtask

  task automatic check_pix(input logic [9:0] x);
    int         dx;
    logic [2:0] e_idx;
    logic       e_v;
    draw_x = x;
    tick();
    dx    = int'(x) - ref_x;
    e_idx = '0;
    e_v   = 1'b0;
    if (ref_hit && dx >= 0 && dx < 32) begin
      e_idx = ref_line[dx];
      e_v   = (ref_line[dx] != 3'd0);
    end
    chk("pix_idx", pix_idx, e_idx);
    chk("pix_valid", pix_valid, e_v);
  endtask

  task automatic apply_tab(input logic f);
    for (int i = 0; i < 15; i++) begin
      if (tab[i].flip == f) begin
        draw_x = tab[i].dx;
        tick();
        chk("tab_pix_idx", pix_idx, tab[i].idx);
        chk("tab_pix_valid", pix_valid, tab[i].v);
      end
    end
  endtask

  initial begin
    // Sprite at x=100, line 53 -> row 3, ROM word i holds i%8.
    tab[0]  = '{1'b0, 10'd99,   3'd0, 1'b0};
    tab[1]  = '{1'b0, 10'd100,  3'd0, 1'b0};
    tab[2]  = '{1'b0, 10'd101,  3'd1, 1'b1};
    tab[3]  = '{1'b0, 10'd107,  3'd7, 1'b1};
    tab[4]  = '{1'b0, 10'd108,  3'd0, 1'b0};
    tab[5]  = '{1'b0, 10'd120,  3'd4, 1'b1};
    tab[6]  = '{1'b0, 10'd131,  3'd7, 1'b1};
    tab[7]  = '{1'b0, 10'd132,  3'd0, 1'b0};
    tab[8]  = '{1'b0, 10'd0,    3'd0, 1'b0};
    tab[9]  = '{1'b0, 10'd1023, 3'd0, 1'b0};
    tab[10] = '{1'b1, 10'd100,  3'd7, 1'b1};
    tab[11] = '{1'b1, 10'd101,  3'd6, 1'b1};
    tab[12] = '{1'b1, 10'd107,  3'd0, 1'b0};
    tab[13] = '{1'b1, 10'd130,  3'd1, 1'b1};
    tab[14] = '{1'b1, 10'd132,  3'd0, 1'b0};

    for (int i = 0; i < 1024; i++) mem[i] = 3'(i % 8);
    ref_hit      = 1'b0;
    ref_x        = 0;
    reset_n      = 1'b0;
    draw_x       = '0;
    bus.start    = 1'b0;
    bus.line_y   = '0;
    bus.sprite_x = '0;
    bus.sprite_y = '0;
    bus.flip_h   = 1'b0;
    #12;
    chk("rst_rom_address", bus.rom_address, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pix_idx", pix_idx, 0);
    chk("rst_pix_valid", pix_valid, 0);
    tick();
    reset_n = 1'b1;
    tick();

    fetch_check(10'd53, 10'd100, 10'd50, 1'b0, 1'b0);
    apply_tab(1'b0);
    fetch_check(10'd53, 10'd100, 10'd50, 1'b1, 1'b0);
    apply_tab(1'b1);

    fetch_check(10'd49, 10'd100, 10'd50, 1'b0, 1'b0);
    for (int x = 95; x < 140; x += 3) check_pix(10'(x));
    fetch_check(10'd53, 10'd100, 10'd50, 1'b0, 1'b0);
    fetch_check(10'd82, 10'd100, 10'd50, 1'b0, 1'b0);
    for (int x = 95; x < 140; x += 3) check_pix(10'(x));

    fetch_check(10'd53, 10'd100, 10'd50, 1'b0, 1'b1);
    apply_tab(1'b0);

    // Reset in the middle of a fetch: immediate zero outputs, no done, hit flags cleared.
    bus.line_y   = 10'd53;
    bus.sprite_x = 10'd100;
    bus.sprite_y = 10'd50;
    bus.flip_h   = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    chk("pre_rst_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rom_address", bus.rom_address, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_pix_idx", pix_idx, 0);
    chk("mid_rst_pix_valid", pix_valid, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_hold_done", bus.done, 0);
    end
    reset_n = 1'b1;
    ref_hit = 1'b0;
    for (int c = 0; c < 25; c++) begin
      chk("post_rst_done", bus.done, 0);
      check_pix(10'd110);
    end
    fetch_check(10'd53, 10'd100, 10'd50, 1'b0, 1'b0);
    apply_tab(1'b0);

    for (int it = 0; it < 25; it++) begin
      int         sx;
      int         sy;
      int         ly;
      int         x;
      logic       f;
      for (int i = 0; i < 1024; i++) mem[i] = 3'($urandom);
      sx = int'($urandom_range(0, 1010));
      sy = int'($urandom_range(0, 500));
      ly = sy + int'($urandom_range(0, 44)) - 6;
      if (ly < 0) ly = 0;
      f = 1'($urandom);
      fetch_check(10'(ly), 10'(sx), 10'(sy), f, 1'b0);
      for (int k = 0; k < 12; k++) begin
        x = sx - 3 + int'($urandom_range(0, 38));
        if (x < 0) x = 0;
        if (x > 1023) x = 1023;
        check_pix(10'(x));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
